rr_tristate_bus_arbiter: RTL and testbench
==========================================

// Module: rr_tristate_bus_arbiter
// PURPOSE
//  N-source shared-bus arbiter and tri-state driver. Sources raise req and present data;
//  the block grants one owner round-robin, drives its data onto a tri-state bus and
//  counts beats against a burst limit. It inserts one all-Z turnaround cycle between
//  owners, so two drivers never overlap. It sits between the source blocks and the
//  common data bus.
// PARAMETERS
//  N_SRC      4   number of sources (>=2)
//  DATA_W     8   bus/data width in bits
//  MAX_BURST  4   max accepted beats per grant before forced rotation (>=1)
//  ID_W       $clog2(N_SRC)  owner index width (localparam)
// PORTS
//  clk        in   1               rising-edge clock
//  rst        in   1               synchronous, active-high reset
//  req        in   N_SRC           per-source request, level-sensitive
//  data_in    in   N_SRC*DATA_W    source i data at [i*DATA_W +: DATA_W]
//  bus_ready  in   1               sink accepts the current beat
//  bus_data   out  DATA_W (tri)    owner data while OWN, else 'z
//  bus_valid  out  1               beat offered: state==OWN && req[owner]
//  grant      out  N_SRC           registered one-hot grant, 0 when no owner
//  owner_id   out  ID_W            index of current/last owner
//  beat_cnt   out  $clog2(MAX_BURST+1)  beats accepted in current grant
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset (at posedge clk with rst=1): state=IDLE, grant=0, owner_id=0, rr_ptr=0,
//   beat_cnt=0. bus_valid=0 and bus_data='z from the next cycle. Reset mid-burst
//   aborts the burst; the beat in that cycle is not counted.
//  FSM states: IDLE, OWN, TURN.
//   IDLE: if |req, pick the first i with req[i]=1, searching i=rr_ptr, rr_ptr+1, ...
//    mod N_SRC. Next edge: grant=onehot(i), owner_id=i, beat_cnt=0, ->OWN.
//    Otherwise stay in IDLE.
//   OWN: bus_data=data_in[owner]; bus_valid=req[owner]. A beat is accepted when
//    bus_valid && bus_ready, and then beat_cnt++.
//    Release occurs if req[owner]==0, or if a beat is accepted with
//    beat_cnt==MAX_BURST-1. On release at the next edge: grant=0,
//    rr_ptr=(owner+1) mod N_SRC, ->TURN.
//   TURN: bus_data='z, bus_valid=0 for exactly one cycle. It arbitrates exactly
//    like IDLE, using the updated rr_ptr: if |req, ->OWN with the new grant;
//    else ->IDLE.
//  Latency: req rising in IDLE -> grant and bus_valid on the next cycle, i.e. 1 clk.
//   Owner-to-owner handover: exactly 1 Z cycle.
//  bus_data is 'z in every state except OWN, and 'z whenever grant==0.
//   grant has at most one bit set.
//  req drop in OWN: bus_valid falls the same cycle, so a coincident bus_ready is not
//   a beat.
//  Sole requester hitting MAX_BURST: it releases, passes TURN, and is re-granted
//   (rotation wraps to itself).
//  rr_ptr wraps N_SRC-1 -> 0. Changes to data_in of non-owners have no bus effect.
//  bus_ready held low: the owner keeps the bus indefinitely (no timeout).
// TESTING (N_SRC=4, DATA_W=8, MAX_BURST=4)
//  1. rst=1 for 2 clk -> grant=0, bus_valid=0, bus_data=8'hzz, beat_cnt=0.
//  2. req=0001, data0=8'hAA, bus_ready=1 -> grant=0001 after 1 clk, 4 beats of AA,
//     then 1 Z cycle, then re-grant 0001.
//  3. req=1111, bus_ready=1 held -> owners 0,1,2,3,0 in order, each 4 beats,
//     1 Z cycle between.
//  4. req=0110 with rr_ptr=3 -> source 1 granted first (wrap search); source 2 next.
//  5. Owner 2 drops req after 2 beats with bus_ready=1 -> beat_cnt stops at 2,
//     bus_valid low that cycle, TURN, then the next requester.
//  6. rst=1 mid-burst (beat_cnt=2) -> next clk grant=0, bus Z, rr_ptr=0, IDLE.
//     Check bus_data never has two drivers (no 'x) in any scenario.

Source files
------------

// File: rtl/rr_tristate_bus_arbiter.sv
// Round-robin arbiter for a shared tri-state data bus with per-grant burst limit.
// One all-Z turnaround cycle is inserted between successive owners.
module rr_tristate_bus_arbiter #(
    parameter  int unsigned N_SRC     = 4,
    parameter  int unsigned DATA_W    = 8,
    parameter  int unsigned MAX_BURST = 4,
    localparam int unsigned ID_W      = $clog2(N_SRC),
    localparam int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_SRC-1:0]        req,
    input  logic [N_SRC*DATA_W-1:0] data_in,
    input  logic                    bus_ready,
    output tri   [DATA_W-1:0]       bus_data,
    output logic                    bus_valid,
    output logic [N_SRC-1:0]        grant,
    output logic [ID_W-1:0]         owner_id,
    output logic [CNT_W-1:0]        beat_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic              pick_valid;
    logic [ID_W-1:0]   pick_id;
    logic [DATA_W-1:0] owner_data;
    logic              accept;
    logic              release_bus;

    // First requester at or after rr_ptr, wrapping modulo N_SRC.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (!pick_valid && req[ID_W'((32'(rr_ptr) + k) % N_SRC)]) begin
                pick_valid = 1'b1;
                pick_id    = ID_W'((32'(rr_ptr) + k) % N_SRC);
            end
        end
    end

    always_comb begin
        owner_data = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (ID_W'(i) == owner_id) begin
                owner_data = data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    // bus_valid follows req combinationally so a dropped request is never a beat.
    assign bus_valid   = (state == OWN) && req[owner_id];
    assign accept      = bus_valid && bus_ready;
    assign release_bus = !req[owner_id] || (accept && (beat_cnt == CNT_W'(MAX_BURST - 1)));
    assign bus_data    = ((state == OWN) && (|grant)) ? owner_data : {DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            owner_id <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE, TURN: begin
                    if (pick_valid) begin
                        state    <= OWN;
                        grant    <= N_SRC'(1) << pick_id;
                        owner_id <= pick_id;
                        beat_cnt <= '0;
                    end else begin
                        state    <= IDLE;
                    end
                end
                OWN: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                    if (release_bus) begin
                        state  <= TURN;
                        grant  <= '0;
                        rr_ptr <= (owner_id == ID_W'(N_SRC - 1)) ? '0 : owner_id + ID_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_tristate_bus_arbiter.sv
// Directed bench for rr_tristate_bus_arbiter: rotation, burst limit, turnaround,
// request drop, stalls and mid-burst reset, with hand-computed expectations.
module tb_rr_tristate_bus_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned MB = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] data_in;
    logic           bus_ready;
    wire  [W-1:0]   bus_data;
    logic           bus_valid;
    logic [N-1:0]   grant;
    logic [1:0]     owner_id;
    logic [2:0]     beat_cnt;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] src_byte [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [7:0] zbyte;

    rr_tristate_bus_arbiter #(.N_SRC(N), .DATA_W(W), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in   (data_in),
        .bus_ready (bus_ready),
        .bus_data  (bus_data),
        .bus_valid (bus_valid),
        .grant     (grant),
        .owner_id  (owner_id),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_own(input string tag, input int src, input int cnt);
        chk_eq({tag, " grant"},    32'(grant),     32'(1) << src);
        chk_eq({tag, " owner"},    32'(owner_id),  32'(src));
        chk_eq({tag, " valid"},    32'(bus_valid), 32'(1));
        chk_eq({tag, " beat_cnt"}, 32'(beat_cnt),  32'(cnt));
        chk_eq({tag, " data"},     32'(bus_data),  32'(src_byte[src]));
    endtask

    task automatic exp_z(input string tag, input int cnt);
        chk_eq({tag, " grant"},    32'(grant),     32'(0));
        chk_eq({tag, " valid"},    32'(bus_valid), 32'(0));
        chk_eq({tag, " beat_cnt"}, 32'(beat_cnt),  32'(cnt));
        chk_eq({tag, " data"},     32'(bus_data),  32'(zbyte));
    endtask

    initial begin
        int seq [6] = '{1, 2, 3, 0, 1, 2};
        zbyte     = 8'hzz;
        rst       = 1'b1;
        req       = '0;
        bus_ready = 1'b0;
        data_in   = {src_byte[3], src_byte[2], src_byte[1], src_byte[0]};

        // reset held two cycles
        repeat (2) tick();
        exp_z("rst", 0);
        chk_eq("rst owner", 32'(owner_id), 32'(0));

        // sole requester: 4 beats, one Z cycle, re-grant to itself
        rst       = 1'b0;
        req       = 4'b0001;
        bus_ready = 1'b1;
        tick();
        exp_own("solo", 0, 0);
        for (int c = 1; c < 4; c++) begin
            tick();
            exp_own("solo", 0, c);
        end
        tick();
        exp_z("solo turn", 4);
        tick();
        exp_own("solo regrant", 0, 0);

        // all request: rotation 0,1,2,3,0,1,2
        req = 4'b1111;
        for (int c = 1; c < 4; c++) begin
            tick();
            exp_own("rot", 0, c);
        end
        for (int s = 0; s < 6; s++) begin
            tick();
            exp_z("rot turn", 4);
            for (int c = 0; c < 4; c++) begin
                tick();
                exp_own("rot", seq[s], c);
            end
        end

        // owner 2 finishes with rr_ptr=3; only 1,2 request -> wrap to 1 then 2
        req = 4'b0110;
        tick();
        exp_z("wrap turn", 4);
        for (int c = 0; c < 4; c++) begin
            tick();
            exp_own("wrap", 1, c);
        end
        tick();
        exp_z("wrap turn2", 4);
        for (int c = 0; c < 3; c++) begin
            tick();
            exp_own("drop", 2, c);
        end

        // owner 2 drops req after 2 beats; coincident bus_ready is not a beat
        req = 4'b0010;
        #1;
        chk_eq("drop valid", 32'(bus_valid), 32'(0));
        chk_eq("drop grant", 32'(grant), 32'(4'b0100));
        chk_eq("drop data", 32'(bus_data), 32'(8'hCC));
        tick();
        exp_z("drop turn", 2);
        tick();
        exp_own("drop next", 1, 0);

        // non-owner data change has no bus effect
        data_in[31:24] = 8'h5A;
        #1;
        chk_eq("nonowner data", 32'(bus_data), 32'(8'hBB));
        data_in[31:24] = src_byte[3];
        for (int c = 1; c < 3; c++) begin
            tick();
            exp_own("prerst", 1, c);
        end

        // reset mid-burst; rr_ptr was 3, so re-grant to 0 proves it cleared
        rst = 1'b1;
        req = 4'b1111;
        tick();
        exp_z("midrst", 0);
        chk_eq("midrst owner", 32'(owner_id), 32'(0));
        rst = 1'b0;
        tick();
        exp_own("postrst", 0, 0);

        // bus_ready low: owner holds the bus, no beats counted
        bus_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            exp_own("stall", 0, 0);
        end
        bus_ready = 1'b1;
        tick();
        exp_own("unstall", 0, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
